// File: rtl/npu_job_arbiter.sv
// Round-robin job arbiter in front of a single 2x2 multiply/ReLU NPU engine.
// Sequences start/busy/done/clear_done, guards each job with a timeout.
module npu_job_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                   S_AXI_ACLK,
   input  logic                   S_AXI_ARESET,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*32-1:0]  req_a,
   input  logic [NUM_REQ*32-1:0]  req_b,
   input  logic [NUM_REQ-1:0]     req_relu,
   output logic                   eng_start,
   output logic [31:0]            eng_a,
   output logic [31:0]            eng_b,
   output logic                   eng_relu,
   output logic                   eng_clear_done,
   input  logic                   eng_busy,
   input  logic                   eng_done,
   input  logic [67:0]            eng_result,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [67:0]            rsp_result,
   output logic                   rsp_err,
   output logic [31:0]            job_count,
   output logic [15:0]            err_count
);

   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] grant;
   logic [TW-1:0]   timer;
   logic [TW-1:0]   timer_inc;
   logic            saw_busy;
   logic            found;
   int              gnt_i;
   logic            done_ok;
   logic            tmo;

   // Cyclic search for the first valid requester at or after rr_ptr.
   always_comb begin
      found = 1'b0;
      gnt_i = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         int j;
         j = int'(rr_ptr) + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!found && req_valid[j]) begin
            found = 1'b1;
            gnt_i = j;
         end
      end
   end

   // A done level left over from an earlier job only counts once busy was seen.
   assign done_ok   = eng_done && saw_busy;
   assign timer_inc = timer + TW'(1);
   assign tmo       = (timer_inc == TW'(TIMEOUT - 1));

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      unique case (state)
         IDLE: begin
            if (found && !S_AXI_ARESET) begin
               req_ready[gnt_i] = 1'b1;
               state_nxt        = ISSUE;
            end
         end
         ISSUE: state_nxt = WAIT;
         WAIT: begin
            if (done_ok || tmo) state_nxt = RESP;
         end
         RESP: begin
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         state          <= IDLE;
         rr_ptr         <= '0;
         grant          <= '0;
         timer          <= '0;
         saw_busy       <= 1'b0;
         eng_start      <= 1'b0;
         eng_a          <= '0;
         eng_b          <= '0;
         eng_relu       <= 1'b0;
         eng_clear_done <= 1'b0;
         rsp_valid      <= 1'b0;
         rsp_id         <= '0;
         rsp_result     <= '0;
         rsp_err        <= 1'b0;
         job_count      <= '0;
         err_count      <= '0;
      end else begin
         state          <= state_nxt;
         eng_start      <= 1'b0;
         eng_clear_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (found) begin
                  grant     <= ID_W'(gnt_i);
                  eng_a     <= req_a[gnt_i*32 +: 32];
                  eng_b     <= req_b[gnt_i*32 +: 32];
                  eng_relu  <= req_relu[gnt_i];
                  eng_start <= 1'b1;
               end
            end
            ISSUE: begin
               timer    <= '0;
               saw_busy <= 1'b0;
            end
            WAIT: begin
               timer <= timer_inc;
               if (eng_busy) saw_busy <= 1'b1;
               if (done_ok) begin
                  rsp_result     <= eng_result;
                  rsp_err        <= 1'b0;
                  rsp_valid      <= 1'b1;
                  rsp_id         <= grant;
                  eng_clear_done <= 1'b1;
               end else if (tmo) begin
                  rsp_result     <= '0;
                  rsp_err        <= 1'b1;
                  rsp_valid      <= 1'b1;
                  rsp_id         <= grant;
                  eng_clear_done <= 1'b1;
                  if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  job_count <= job_count + 32'd1;
                  if (grant == ID_W'(NUM_REQ - 1)) rr_ptr <= '0;
                  else rr_ptr <= grant + ID_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/npu_job_arbiter.md
Name: npu_job_arbiter

Overview:
Shares one 2x2 elementwise-multiply/ReLU NPU engine between NUM_REQ independent requesters, such as a CPU-side AXI shim and DMA descriptor readers. It arbitrates round-robin and accepts one job at a time. It sequences the engine's start/busy/done/clear_done protocol, guards each job with a timeout, and returns the four results tagged with the requester ID. It sits between the requester fabric and the NPU engine core, in the same clock domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of grant/response ID; must satisfy 2**ID_W >= NUM_REQ
TIMEOUT, 64, WAIT-state cycle limit before a job is aborted with an error (>= 8)

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESET  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  per-requester job request
req_ready  out  NUM_REQ  one-hot, 1-cycle accept pulse
req_a  in  NUM_REQ*32  per requester, A operands: bytes [7:0]=a00, [15:8]=a01, [23:16]=a10, [31:24]=a11 (signed int8)
req_b  in  NUM_REQ*32  B operands, same packing as req_a
req_relu  in  NUM_REQ  ReLU enable per requester
eng_start  out  1  start pulse to engine
eng_a, eng_b  out  32 each  operands held stable from ISSUE until the job leaves WAIT
eng_relu  out  1  ReLU enable, held with the operands
eng_clear_done  out  1  1-cycle done-clear pulse
eng_busy  in  1  engine busy
eng_done  in  1  engine done (sticky level)
eng_result  in  68  {c11,c10,c01,c00}, 17-bit signed each; c00 in [16:0]
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  ID_W  requester index of this response
rsp_result  out  68  captured results, same packing as eng_result
rsp_err  out  1  1 = job timed out; result is zero
job_count  out  32  completed jobs, including errored jobs
err_count  out  16  timed-out jobs; saturates at 0xFFFF

Behaviour:
- Reset (synchronous, high) forces state IDLE and zeroes every output register: req_ready, eng_*, rsp_*, both counters. It also clears the round-robin pointer rr_ptr, the timer and saw_busy. Reset asserted in any state, including mid-WAIT, abandons the job. No response is issued for it.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid is set, grant the first valid index at or after rr_ptr, searching cyclically.
  - In that same cycle: req_ready[grant]=1 for exactly one cycle, and latch that requester's a, b, relu into eng_a/eng_b/eng_relu.
  - Store the grant index and move to ISSUE.
  - With no valid request, remain in IDLE; req_ready stays 0.
  - A requester may drop req_valid before being granted. It is never granted on a stale request.
- ISSUE: eng_start=1 for one cycle. Clear the timer and saw_busy. Go to WAIT.
- WAIT:
  - The timer increments each cycle.
  - saw_busy is set when eng_busy=1.
  - eng_done is accepted only when saw_busy=1, or was set in an earlier cycle. This prevents a stale done from a prior job being taken as completion.
  - Accepted done: capture eng_result into rsp_result, set rsp_err=0, pulse eng_clear_done for 1 cycle, go to RESP.
  - If the timer reaches TIMEOUT-1 without an accepted done: rsp_result=0, rsp_err=1, pulse eng_clear_done, increment err_count (saturating), go to RESP.
  - If done is accepted in the same cycle the timer reaches TIMEOUT-1, done takes priority.
- RESP:
  - rsp_valid=1 and rsp_id=grant. rsp_result, rsp_err and rsp_id stay stable while rsp_valid=1 and rsp_ready=0.
  - On handshake (rsp_valid and rsp_ready): rsp_valid drops the next cycle, job_count increments (wraps at 2^32), rr_ptr = (grant+1) mod NUM_REQ, go to IDLE.
  - No new grant is issued until the response is accepted.
- Latency:
  - The accept cycle is T.
  - eng_start is high at T+1.
  - If done is accepted in cycle D, rsp_valid is high from D+1.
  - The minimum gap from one response handshake to the next req_ready is 1 cycle (the IDLE cycle).
- Invariants: at most one req_ready bit set at a time; eng_start is never asserted outside ISSUE.

Test Plan:
1. Single job from req 1: a=(2,-3,4,5), b=(3,4,-2,6), relu=0, behavioural engine with 4-cycle busy. Required: eng_start 1 cycle after req_ready[1]; rsp_result = c00=6, c01=-12 (0x1FFF4), c10=-8, c11=30; rsp_id=1; rsp_err=0; job_count=1.
2. Same operands with relu=1, engine applying ReLU. Required: rsp_result = 6, 0, 0, 30; eng_relu=1 throughout WAIT.
3. All 4 req_valid held high with rsp_ready=1. Required: grant order 0,1,2,3,0,1; never two req_ready bits set in one cycle.
4. Engine never asserts busy or done, TIMEOUT=16. Required: rsp_valid exactly 16 cycles after ISSUE; rsp_err=1; rsp_result=0; err_count=1; one eng_clear_done pulse.
5. eng_done held high (stale) through ISSUE with busy delayed 3 cycles. Required: done not accepted before busy is seen; the response carries the new job's result.
6. rsp_ready held low 5 cycles in RESP with req 2 pending. Required: rsp_* stable and no req_ready during the stall. Then assert S_AXI_ARESET mid-WAIT on the next job. Required: next cycle all outputs 0, state IDLE, no response emitted.
